// File: rtl/axi_mm_slave_wr_sched_if.sv
// Handshake bundle between link RX, user AXI slave write channels and scheduler status.
// The slave modport is the scheduler's view; master is the surrounding environment's view.
interface axi_mm_slave_wr_sched_if #(
    parameter int CNT_W = 4
);
    logic             lnk_awvalid;
    logic [7:0]       lnk_awlen;
    logic             lnk_awready;
    logic             usr_awvalid;
    logic             usr_awready;
    logic             lnk_wvalid;
    logic             lnk_wlast;
    logic             lnk_wready;
    logic             usr_wvalid;
    logic             usr_wlast;
    logic             usr_wready;
    logic             b_hs;
    logic [CNT_W-1:0] outstanding;
    logic             len_err;
    logic             b_underflow;
    logic             clr_err;

    modport slave (
        input  lnk_awvalid, lnk_awlen, usr_awready, lnk_wvalid, lnk_wlast,
               usr_wready, b_hs, clr_err,
        output lnk_awready, usr_awvalid, lnk_wready, usr_wvalid, usr_wlast,
               outstanding, len_err, b_underflow
    );

    modport master (
        output lnk_awvalid, lnk_awlen, usr_awready, lnk_wvalid, lnk_wlast,
               usr_wready, b_hs, clr_err,
        input  lnk_awready, usr_awvalid, lnk_wready, usr_wvalid, usr_wlast,
               outstanding, len_err, b_underflow
    );
endinterface

// File: rtl/axi_mm_slave_wr_sched.sv
// Write scheduler: AW passes combinationally when tracker/outstanding room exists; W released >=2 cycles after AW.
// Backpressure: AW stalls on full length FIFO or outstanding cap; W follows user ready, WLAST rebuilt from AWLEN.
module axi_mm_slave_wr_sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_dat;
    end

    assign o_dat   = r_mem[r_rd_ptr];
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
endmodule

module axi_mm_slave_wr_sched #(
    parameter int LEN_FIFO_DEPTH  = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input logic                      clk_wr,
    input logic                      rst_wr,
    axi_mm_slave_wr_sched_if.slave   bus
);
    typedef enum logic {W_IDLE, W_BURST} w_state_t;

    w_state_t         r_state;
    w_state_t         w_state_nxt;
    logic [7:0]       r_beat_cnt;
    logic [7:0]       w_beat_nxt;
    logic [CNT_W-1:0] r_outstanding;
    logic             r_len_err;
    logic             r_b_underflow;

    logic             w_pop;
    logic             w_len_err_nxt;
    logic             w_usr_wvalid;
    logic             w_lnk_wready;
    logic             w_usr_wlast;
    logic [7:0]       w_fifo_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_aw_ok;
    logic             w_aw_hs;
    logic             w_underflow_set;

    // Registered full is used on purpose: a pop in the same cycle does not reopen AW.
    assign w_aw_ok = !w_fifo_full && (r_outstanding < CNT_W'(MAX_OUTSTANDING));
    assign w_aw_hs = bus.lnk_awvalid & bus.usr_awready & w_aw_ok;

    axi_mm_slave_wr_sched_fifo #(
        .W     (8),
        .DEPTH (LEN_FIFO_DEPTH)
    ) u_len_fifo (
        .clk     (clk_wr),
        .rst     (rst_wr),
        .i_push  (w_aw_hs),
        .i_dat   (bus.lnk_awlen),
        .i_pop   (w_pop),
        .o_dat   (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            r_state    <= W_IDLE;
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_len_err  <= w_len_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat_cnt;
        w_pop         = 1'b0;
        w_len_err_nxt = 1'b0;
        w_usr_wvalid  = 1'b0;
        w_lnk_wready  = 1'b0;
        w_usr_wlast   = 1'b0;
        case (r_state)
            W_IDLE: begin
                if (!w_fifo_empty) begin
                    w_beat_nxt  = w_fifo_head;
                    w_pop       = 1'b1;
                    w_state_nxt = W_BURST;
                end
            end
            W_BURST: begin
                w_usr_wvalid = bus.lnk_wvalid;
                w_lnk_wready = bus.usr_wready;
                w_usr_wlast  = (r_beat_cnt == 8'd0);
                if (bus.lnk_wvalid && bus.usr_wready) begin
                    if (r_beat_cnt != 8'd0) begin
                        w_beat_nxt    = r_beat_cnt - 8'd1;
                        w_len_err_nxt = bus.lnk_wlast;
                    end else begin
                        w_len_err_nxt = !bus.lnk_wlast;
                        // Chain straight into the next tracked burst without an idle bubble.
                        if (!w_fifo_empty) begin
                            w_beat_nxt = w_fifo_head;
                            w_pop      = 1'b1;
                        end else begin
                            w_state_nxt = W_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign w_underflow_set = bus.b_hs & !w_aw_hs & (r_outstanding == '0);

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            r_outstanding <= '0;
            r_b_underflow <= 1'b0;
        end else begin
            if (w_aw_hs && !bus.b_hs) begin
                r_outstanding <= r_outstanding + CNT_W'(1);
            end else if (!w_aw_hs && bus.b_hs && (r_outstanding != '0)) begin
                r_outstanding <= r_outstanding - CNT_W'(1);
            end
            if (w_underflow_set) begin
                r_b_underflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_b_underflow <= 1'b0;
            end
        end
    end

    assign bus.usr_awvalid = !rst_wr & bus.lnk_awvalid & w_aw_ok;
    assign bus.lnk_awready = !rst_wr & bus.usr_awready & w_aw_ok;
    assign bus.usr_wvalid  = !rst_wr & w_usr_wvalid;
    assign bus.lnk_wready  = !rst_wr & w_lnk_wready;
    assign bus.usr_wlast   = !rst_wr & w_usr_wlast;
    assign bus.outstanding = r_outstanding;
    assign bus.len_err     = r_len_err;
    assign bus.b_underflow = r_b_underflow;
endmodule
